// File: rtl/ysyx_22050078_lsu_pkg.sv
// Shared encodings for the handshaked load/store unit.
package ysyx_22050078_lsu_pkg;

    localparam int DEFAULT_XLEN = 64;

    // Access size as carried on i_size.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // One outstanding transaction: accept, request, wait for response, report.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/ysyx_22050078_lsu_align.sv
// Combinational byte-lane steering: store data/strobe placement, load
// extraction with sign/zero extension, and alignment legality.
module ysyx_22050078_lsu_align
    import ysyx_22050078_lsu_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [2:0]          addr_lo,
    input  size_e               size,
    input  logic                is_unsigned,
    input  logic [XLEN-1:0]     wdata,
    input  logic [XLEN-1:0]     rdata,
    output logic [XLEN-1:0]     lane_wdata,
    output logic [XLEN/8-1:0]   lane_wstrb,
    output logic [XLEN-1:0]     load_data,
    output logic                misalign
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);

    logic [OFFW-1:0] off;
    logic [OFFW+2:0] bit_off;
    logic [7:0]      base_mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic            sign;

    assign off        = addr_lo[OFFW-1:0];
    assign bit_off    = {off, 3'b000};
    assign lane_wdata = wdata << bit_off;
    assign lane_wstrb = NBYTES'(base_mask) << off;
    assign shifted    = rdata >> bit_off;

    // Per-size strobe base, kept-bit mask, sign bit and alignment check.
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        base_mask = 8'hFF;
        keep      = '1;
        sign      = 1'b0;
        misalign  = 1'b0;
        case (size)
            SZ_B: begin
                base_mask = 8'h01;
                keep      = XLEN'(8'hFF);
                sign      = shifted[7];
            end
            SZ_H: begin
                base_mask = 8'h03;
                keep      = XLEN'(16'hFFFF);
                sign      = shifted[15];
                misalign  = addr_lo[0];
            end
            SZ_W: begin
                base_mask = 8'h0F;
                keep      = XLEN'(32'hFFFF_FFFF);
                sign      = shifted[31];
                misalign  = |addr_lo[1:0];
            end
            default: begin
                misalign  = (|addr_lo[2:0]) || (XLEN == 32);
            end
        endcase
        load_data = (shifted & keep) | ((sign && !is_unsigned) ? ~keep : '0);
    end

endmodule

// File: rtl/ysyx_22050078_lsu_bus.sv
// Handshaked load/store unit: one outstanding request on a req/gnt/rvalid
// memory port, with misalignment and bus-error reporting.
module ysyx_22050078_lsu_bus
    import ysyx_22050078_lsu_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_we,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [XLEN-1:0]     i_addr,
    input  logic [XLEN-1:0]     i_wdata,
    output logic                o_done,
    output logic [XLEN-1:0]     o_rdata,
    output logic                o_misalign,
    output logic                o_err,
    output logic                o_mem_req,
    input  logic                i_mem_gnt,
    output logic                o_mem_we,
    output logic [XLEN-1:0]     o_mem_addr,
    output logic [XLEN-1:0]     o_mem_wdata,
    output logic [XLEN/8-1:0]   o_mem_wstrb,
    input  logic                i_mem_rvalid,
    input  logic [XLEN-1:0]     i_mem_rdata,
    input  logic                i_mem_err
);

    localparam int NBYTES = XLEN / 8;

    state_e              state, state_nxt;
    logic                we_q;
    size_e               size_q;
    logic                uns_q;
    logic [2:0]          addr_lo_q;
    logic                misalign_q;
    logic                err_q;
    logic [XLEN-1:0]     rdata_q;

    logic                idle;
    logic                accept;
    size_e               al_size;
    logic [2:0]          al_addr_lo;
    logic [XLEN-1:0]     al_wdata;
    logic [NBYTES-1:0]   al_wstrb;
    logic [XLEN-1:0]     al_rdata;
    logic                al_misalign;

    assign idle   = (state == ST_IDLE);
    assign accept = idle && i_valid;

    // In IDLE the aligner sees the incoming request; afterwards it sees the
    // latched request so the response can be extracted.
    assign al_size    = idle ? size_e'(i_size) : size_q;
    assign al_addr_lo = idle ? i_addr[2:0] : addr_lo_q;

    ysyx_22050078_lsu_align #(.XLEN(XLEN)) u_align (
        .addr_lo     (al_addr_lo),
        .size        (al_size),
        .is_unsigned (uns_q),
        .wdata       (i_wdata),
        .rdata       (i_mem_rdata),
        .lane_wdata  (al_wdata),
        .lane_wstrb  (al_wstrb),
        .load_data   (al_rdata),
        .misalign    (al_misalign)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_valid)      state_nxt = al_misalign ? ST_RESP : ST_REQ;
            ST_REQ:  if (i_mem_gnt)    state_nxt = ST_WAIT;
            ST_WAIT: if (i_mem_rvalid) state_nxt = ST_RESP;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Request latch on accept, response capture in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            addr_lo_q   <= '0;
            misalign_q  <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
        end else if (accept) begin
            we_q       <= i_we;
            size_q     <= size_e'(i_size);
            uns_q      <= i_unsigned;
            addr_lo_q  <= i_addr[2:0];
            misalign_q <= al_misalign;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            if (!al_misalign) begin
                o_mem_we    <= i_we;
                o_mem_addr  <= i_addr & ~XLEN'(NBYTES - 1);
                o_mem_wdata <= i_we ? al_wdata : '0;
                o_mem_wstrb <= i_we ? al_wstrb : '0;
            end
        end else if (state == ST_WAIT && i_mem_rvalid) begin
            err_q   <= i_mem_err;
            rdata_q <= (we_q || i_mem_err) ? '0 : al_rdata;
        end
    end

    assign o_ready    = idle;
    assign o_mem_req  = (state == ST_REQ);
    assign o_done     = (state == ST_RESP);
    assign o_rdata    = rdata_q;
    assign o_misalign = misalign_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_ysyx_22050078_lsu_bus.sv
// Directed bench for the handshaked LSU: a reactive memory responder with
// configurable grant delay, hand-computed expectations, reset-in-flight case.
module tb_ysyx_22050078_lsu_bus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 64-bit instance
    logic        i_valid = 0, i_we = 0, i_unsigned = 0;
    logic [1:0]  i_size = 0;
    logic [63:0] i_addr = 0, i_wdata = 0;
    logic        o_ready, o_done, o_misalign, o_err, o_mem_req, o_mem_we;
    logic [63:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [7:0]  o_mem_wstrb;
    logic        i_mem_gnt = 0, i_mem_rvalid = 0, i_mem_err = 0;
    logic [63:0] i_mem_rdata = 0;

    // 32-bit instance (illegal double access only)
    logic        v32 = 0;
    logic [1:0]  size32 = 0;
    logic [31:0] addr32 = 0;
    logic        ready32, done32, mis32, err32, req32, mwe32;
    logic [31:0] rdata32, maddr32, mwdata32;
    logic [3:0]  mstrb32;

    always #5 clk = ~clk;

    ysyx_22050078_lsu_bus #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_ready(o_ready), .i_we(i_we), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_done(o_done), .o_rdata(o_rdata), .o_misalign(o_misalign), .o_err(o_err),
        .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err)
    );

    ysyx_22050078_lsu_bus #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst),
        .i_valid(v32), .o_ready(ready32), .i_we(1'b0), .i_size(size32),
        .i_unsigned(1'b0), .i_addr(addr32), .i_wdata(32'h0),
        .o_done(done32), .o_rdata(rdata32), .o_misalign(mis32), .o_err(err32),
        .o_mem_req(req32), .i_mem_gnt(1'b1), .o_mem_we(mwe32),
        .o_mem_addr(maddr32), .o_mem_wdata(mwdata32), .o_mem_wstrb(mstrb32),
        .i_mem_rvalid(1'b1), .i_mem_rdata(32'hFFFF_FFFF), .i_mem_err(1'b0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    // Results of the last transaction
    int          r_lat;
    logic [63:0] r_rdata, r_maddr, r_mwdata;
    logic [7:0]  r_mstrb;
    logic        r_mis, r_err, r_mwe, r_saw_req, r_unstable, r_ready_bad;

    // Issue one request and act as memory: grant after gnt_wait request
    // cycles, respond the cycle after the grant.
    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rsp_data, input logic rsp_err, input int gnt_wait);
        int   req_cnt;
        logic granted;
        @(negedge clk);
        check("ready_before_accept", o_ready, 1'b1);
        i_valid = 1; i_we = we; i_size = size; i_unsigned = uns; i_addr = addr; i_wdata = wdata;
        @(posedge clk);
        r_lat = -1; r_saw_req = 0; r_unstable = 0; r_ready_bad = 0;
        r_maddr = 0; r_mwdata = 0; r_mstrb = 0; r_mwe = 0;
        req_cnt = 0; granted = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            i_valid = 0; i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_err = 0; i_mem_rdata = 0;
            if (o_done) begin
                r_lat = c; r_rdata = o_rdata; r_mis = o_misalign; r_err = o_err;
                break;
            end
            if (o_ready) r_ready_bad = 1;
            if (o_mem_req) begin
                if (!r_saw_req) begin
                    r_maddr = o_mem_addr; r_mwdata = o_mem_wdata; r_mstrb = o_mem_wstrb; r_mwe = o_mem_we;
                end else if (o_mem_addr !== r_maddr || o_mem_wdata !== r_mwdata ||
                             o_mem_wstrb !== r_mstrb || o_mem_we !== r_mwe) begin
                    r_unstable = 1;
                end
                r_saw_req = 1;
                if (req_cnt == gnt_wait) begin
                    i_mem_gnt = 1; granted = 1;
                end
                req_cnt++;
            end else if (granted) begin
                i_mem_rvalid = 1; i_mem_rdata = rsp_data; i_mem_err = rsp_err; granted = 0;
            end
        end
        if (r_lat < 0) $display("FAIL timeout: no o_done within 60 cycles");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        #12;
        check("rst_ready", o_ready, 1'b1);
        check("rst_done", o_done, 1'b0);
        check("rst_rdata", o_rdata, 64'h0);
        check("rst_flags", {o_misalign, o_err, o_mem_req, o_mem_we}, 4'b0);
        check("rst_mem_addr", o_mem_addr, 64'h0);
        check("rst_mem_wdata", o_mem_wdata, 64'h0);
        check("rst_mem_wstrb", o_mem_wstrb, 8'h0);
        @(negedge clk);
        rst = 0;

        // Double load, best-case latency
        txn(0, 2'd3, 0, 64'h8000_0008, 0, 64'h1122_3344_5566_7788, 0, 0);
        check("ld_d_lat", r_lat, 3);
        check("ld_d_addr", r_maddr, 64'h8000_0008);
        check("ld_d_we_strb", {r_mwe, r_mstrb}, 9'h0);
        check("ld_d_rdata", r_rdata, 64'h1122_3344_5566_7788);
        check("ld_d_flags", {r_mis, r_err, r_ready_bad}, 3'b0);

        // Signed / unsigned byte loads (next accept directly at T+4)
        txn(0, 2'd0, 0, 64'h8000_0003, 0, 64'h0000_0000_8000_0000, 0, 0);
        check("ld_b_addr", r_maddr, 64'h8000_0000);
        check("ld_b_signed", r_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        txn(0, 2'd0, 1, 64'h8000_0003, 0, 64'h0000_0000_8000_0000, 0, 0);
        check("ld_bu", r_rdata, 64'h0000_0000_0000_0080);

        // Signed half and word loads at non-zero lanes
        txn(0, 2'd1, 0, 64'h8000_000A, 0, 64'h0000_0000_8765_0000, 0, 0);
        check("ld_h_addr", r_maddr, 64'h8000_0008);
        check("ld_h_signed", r_rdata, 64'hFFFF_FFFF_FFFF_8765);
        txn(0, 2'd2, 0, 64'h8000_0004, 0, 64'h8000_0001_0000_0000, 0, 0);
        check("ld_w_signed", r_rdata, 64'hFFFF_FFFF_8000_0001);

        // Half store in top lanes
        txn(1, 2'd1, 0, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 64'hDEAD_DEAD_DEAD_DEAD, 0, 0);
        check("st_h_lat", r_lat, 3);
        check("st_h_addr", r_maddr, 64'h8000_0000);
        check("st_h_we", r_mwe, 1'b1);
        check("st_h_wstrb", r_mstrb, 8'hC0);
        check("st_h_wdata_hi", r_mwdata[63:48], 16'hBEEF);
        check("st_h_rdata", r_rdata, 64'h0);

        // Word store in upper lanes
        txn(1, 2'd2, 0, 64'h8000_0004, 64'h1234_5678_9ABC_DEF0, 0, 0, 0);
        check("st_w_wstrb", r_mstrb, 8'hF0);
        check("st_w_wdata", r_mwdata, 64'h9ABC_DEF0_0000_0000);

        // Misaligned word load and double store: done at T+1, no request
        txn(0, 2'd2, 0, 64'h8000_0002, 0, 0, 0, 0);
        check("mis_w_lat", r_lat, 1);
        check("mis_w_flags", {r_mis, r_err, r_saw_req}, 3'b100);
        check("mis_w_rdata", r_rdata, 64'h0);
        txn(1, 2'd3, 0, 64'h8000_0004, 64'h1, 0, 0, 0);
        check("mis_d_st", {r_lat[3:0], r_mis, r_saw_req}, {4'd1, 1'b1, 1'b0});

        // Grant delayed 4 cycles, bus error on the response
        txn(0, 2'd2, 0, 64'h8000_0014, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4);
        check("gnt_delay_lat", r_lat, 7);
        check("gnt_delay_stable", r_unstable, 1'b0);
        check("gnt_delay_ready_low", r_ready_bad, 1'b0);
        check("gnt_delay_addr", r_maddr, 64'h8000_0010);
        check("err_flags", {r_err, r_mis}, 2'b10);
        check("err_rdata", r_rdata, 64'h0);

        // XLEN=32: double access is illegal
        @(negedge clk);
        v32 = 1; size32 = 2'd3; addr32 = 32'h8000_0000;
        @(negedge clk);
        v32 = 0;
        check("x32_d_done", {done32, mis32, err32, req32}, 4'b1100);
        @(negedge clk);
        check("x32_d_idle", {ready32, done32, req32}, 3'b100);

        // Reset while waiting for the response
        @(negedge clk);
        i_valid = 1; i_we = 0; i_size = 2'd3; i_unsigned = 0; i_addr = 64'h8000_0020;
        @(negedge clk);
        i_valid = 0;
        check("rst_mid_req", o_mem_req, 1'b1);
        i_mem_gnt = 1;
        @(negedge clk);
        i_mem_gnt = 0;
        check("rst_mid_in_wait", {o_mem_req, o_ready, o_done}, 3'b000);
        #1 rst = 1;
        #1;
        check("rst_mid_ready", o_ready, 1'b1);
        check("rst_mid_outs", {o_done, o_misalign, o_err, o_mem_req, o_mem_we}, 5'b0);
        check("rst_mid_addr", o_mem_addr, 64'h0);
        check("rst_mid_rdata", o_rdata, 64'h0);
        @(negedge clk);
        rst = 0;
        i_mem_rvalid = 1; i_mem_rdata = 64'h5555_5555_5555_5555;
        @(negedge clk);
        i_mem_rvalid = 0;
        check("late_rvalid_no_done", {o_done, o_ready}, 2'b01);
        @(negedge clk);
        check("late_rvalid_idle", {o_done, o_ready, o_mem_req}, 3'b010);

        // Normal transaction after reset
        txn(0, 2'd1, 1, 64'h8000_0022, 0, 64'h0000_0000_F00D_0000, 0, 1);
        check("post_rst_lat", r_lat, 4);
        check("post_rst_rdata", r_rdata, 64'h0000_0000_0000_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
